wr_burst_ctrl: RTL
==================

WR_BURST_CTRL -- requirements
Module: wr_burst_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- ADDR_WIDTH, 26, byte-address width.
- DATA_WIDTH, 32, data word width.
- FIFO_DEPTH, 64, buffer depth in words; power of two, at least 2*WBURST_LEN.
- WBURST_LEN, 8'd8, words per burst.
- ADDR_STEP, 4, address increment per word.
- BASE_ADDR, 0, first burst address.
- END_ADDR, 2^ADDR_WIDTH-1, last usable address.
REQ-002 Ports SHALL be as follows, one per line: name direction width meaning.
- clk in 1: single clock.
- rst_n in 1: synchronous, active-low reset.
- init_end in 1: memory initialised; no burst is requested while low.
- usr_wr_en in 1: push usr_wr_data this cycle.
- usr_wr_data in DATA_WIDTH: user write word.
- usr_full out 1: buffer full.
- usr_level out $clog2(FIFO_DEPTH)+1: words held.
- wr_trig out 1: one-cycle burst request to the write master.
- wr_len out 8: burst length, constant WBURST_LEN.
- wr_addr out ADDR_WIDTH: burst start address.
- wr_data out DATA_WIDTH: FIFO head word (first-word-fall-through).
- wr_data_en in 1: write master consumed wr_data; pop.
- wr_ready in 1: write master idle.
- wr_done in 1: one-cycle burst-complete pulse.
- busy out 1: burst outstanding.
- ovf_err out 1: sticky, push attempted while full.
- udf_err out 1: sticky, pop attempted while empty.

Function
REQ-003 The FIFO SHALL be circular with read and write pointers wrapping modulo FIFO_DEPTH and level = pushes - pops.
REQ-004 A push with usr_full=1 SHALL be dropped, leave the level unchanged, and set ovf_err.
REQ-005 A pop with level=0 SHALL be ignored and SHALL set udf_err.
REQ-006 A simultaneous push and pop with 0<level<FIFO_DEPTH SHALL perform both operations and leave the level unchanged.
REQ-007 A simultaneous push and pop at level=0 SHALL perform the push only and set udf_err.
REQ-008 A simultaneous push and pop at level=FIFO_DEPTH SHALL perform both operations and SHALL NOT set ovf_err.
REQ-009 wr_data SHALL equal the word at the read pointer combinationally; its value SHALL be don't-care while level=0.
REQ-010 FSM states SHALL be IDLE, REQ and WAIT.
- IDLE -> REQ when init_end=1, wr_ready=1 and level>=WBURST_LEN.
- REQ -> WAIT unconditionally.
- WAIT -> IDLE on wr_done=1.
REQ-011 wr_trig SHALL be 1 only in REQ, giving exactly one pulse per burst.
REQ-012 busy SHALL be 1 in REQ and WAIT.
REQ-013 The burst decision SHALL be registered, so wr_trig asserts one cycle after the IDLE condition holds.
REQ-014 wr_addr SHALL be held stable from entry to REQ until the cycle after wr_done.
REQ-015 On wr_done the next address SHALL be computed as next = wr_addr + WBURST_LEN*ADDR_STEP, evaluated in ADDR_WIDTH+1 bits.
REQ-016 If next + WBURST_LEN*ADDR_STEP - 1 > END_ADDR, wr_addr SHALL load BASE_ADDR; otherwise it SHALL load next.
REQ-017 wr_done received outside WAIT SHALL be ignored.
REQ-018 init_end falling in REQ or WAIT SHALL NOT abort the burst in progress; it SHALL only block the next burst.
REQ-019 Pushes SHALL be accepted in all states, including while init_end=0.

Reset
REQ-020 When rst_n=0 at a clk edge, the following SHALL be cleared: state=IDLE, pointers=0, level=0, wr_trig=0, busy=0, wr_addr=BASE_ADDR, ovf_err=0, udf_err=0, usr_full=0.
REQ-021 A reset mid-burst SHALL discard buffered data and the outstanding burst, and operation SHALL restart from BASE_ADDR.
REQ-022 wr_len SHALL equal WBURST_LEN at all times, including during reset.

Verification
REQ-023 The bench SHALL cover the following directed scenarios.
- Push 8 words 0x1..0x8 with init_end=1 and wr_ready=1: one wr_trig pulse two cycles after the 8th push, wr_addr=0.
- Pop the 8 words via wr_data_en, then pulse wr_done: data order is 0x1..0x8, wr_addr becomes 0x20, busy falls.
- Push 7 words: no wr_trig. Then push the 8th word with init_end=0: still no wr_trig. Raise init_end: wr_trig follows.
- Fill 64 words and push a 65th: usr_full=1, word dropped, ovf_err=1. Pop and push together at full: level stays 64, ovf_err unchanged.
- Set END_ADDR=0x3F, run 2 bursts: wr_addr sequence is 0x00, 0x20, 0x00.
- Assert rst_n=0 in WAIT with level=5: next cycle level=0, busy=0, wr_addr=0, and a stray wr_done is ignored.

Source files
------------

// File: rtl/wr_burst_ctrl.sv
// wr_burst_ctrl
//   Buffers user write words in a circular FIFO and issues fixed-length burst
//   requests to a downstream write master. The master pops words
//   (first-word-fall-through) and signals completion with wr_done. Burst
//   start addresses advance by one burst per completed burst and wrap back
//   to BASE_ADDR when the next burst would run past END_ADDR.
//
// Ports
//   clk, rst_n       : clock, synchronous active-low reset
//   init_end         : memory ready; gates new bursts only
//   usr_wr_en/_data  : user push interface
//   usr_full         : FIFO holds FIFO_DEPTH words
//   usr_level        : words currently held
//   wr_trig          : one-cycle burst request
//   wr_len           : burst length (constant WBURST_LEN)
//   wr_addr          : burst start address
//   wr_data          : FIFO head word
//   wr_data_en       : master consumed wr_data (pop)
//   wr_ready         : master idle
//   wr_done          : burst-complete pulse
//   busy             : burst outstanding
//   ovf_err, udf_err : sticky overflow / underflow flags
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | no burst outstanding; waiting for enough data
// S_REQ  | wr_trig high for one cycle
// S_WAIT | burst in flight; waiting for wr_done

module wr_burst_ctrl #(
   parameter int                    ADDR_WIDTH = 26,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 64,
   parameter logic [7:0]            WBURST_LEN = 8'd8,
   parameter int                    ADDR_STEP  = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [ADDR_WIDTH-1:0] END_ADDR   = '1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          init_end,
   input  logic                          usr_wr_en,
   input  logic [DATA_WIDTH-1:0]         usr_wr_data,
   output logic                          usr_full,
   output logic [$clog2(FIFO_DEPTH):0]   usr_level,
   output logic                          wr_trig,
   output logic [7:0]                    wr_len,
   output logic [ADDR_WIDTH-1:0]         wr_addr,
   output logic [DATA_WIDTH-1:0]         wr_data,
   input  logic                          wr_data_en,
   input  logic                          wr_ready,
   input  logic                          wr_done,
   output logic                          busy,
   output logic                          ovf_err,
   output logic                          udf_err
);

   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int LW  = PW + 1;
   localparam int AXW = ADDR_WIDTH + 2;

   localparam logic [LW-1:0]  DEPTH_LVL   = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0]  BURST_LVL   = LW'(WBURST_LEN);
   localparam logic [AXW-1:0] BURST_BYTES = AXW'(int'(WBURST_LEN) * ADDR_STEP);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t                  state_q;
   logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]           level_q, level_d;
   logic                    ovf_q, ovf_d;
   logic                    udf_q, udf_d;
   logic                    wr_trig_q;
   logic                    busy_q;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    fifo_empty, fifo_full;
   logic                    do_push, do_pop;
   logic [AXW-1:0]          nxt_x, last_x;

   // A pop at full frees a slot in the same cycle, so the push is accepted
   // and no overflow is flagged. A pop at empty is never performed.
   always_comb begin
      fifo_empty = (level_q == '0);
      fifo_full  = (level_q == DEPTH_LVL);
      do_pop     = wr_data_en && !fifo_empty;
      do_push    = usr_wr_en && (!fifo_full || do_pop);

      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      level_d = level_q;
      if (do_push && !do_pop) begin
         level_d = level_q + LW'(1);
      end else if (!do_push && do_pop) begin
         level_d = level_q - LW'(1);
      end

      ovf_d = ovf_q | (usr_wr_en & ~do_push);
      udf_d = udf_q | (wr_data_en & fifo_empty);
   end

   // Extra headroom bits keep the end-of-burst check free of wrap-around
   // even when the address sits at the top of the ADDR_WIDTH range.
   always_comb begin
      nxt_x  = {2'b00, addr_q} + BURST_BYTES;
      last_x = nxt_x + BURST_BYTES - AXW'(1);
      addr_d = (last_x > {2'b00, END_ADDR}) ? BASE_ADDR : nxt_x[ADDR_WIDTH-1:0];
   end

   // Storage carries no reset; stale words are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= usr_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // init_end only gates leaving S_IDLE; a burst already requested runs to
   // wr_done regardless. wr_done outside S_WAIT has no effect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         wr_trig_q <= 1'b0;
         busy_q    <= 1'b0;
         addr_q    <= BASE_ADDR;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (init_end && wr_ready && (level_q >= BURST_LVL)) begin
                  state_q   <= S_REQ;
                  wr_trig_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            S_REQ: begin
               state_q   <= S_WAIT;
               wr_trig_q <= 1'b0;
            end
            S_WAIT: begin
               if (wr_done) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  addr_q  <= addr_d;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               wr_trig_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign usr_full  = fifo_full;
   assign usr_level = level_q;
   assign wr_trig   = wr_trig_q;
   assign wr_len    = WBURST_LEN;
   assign wr_addr   = addr_q;
   assign wr_data   = mem_q[rd_ptr_q];
   assign busy      = busy_q;
   assign ovf_err   = ovf_q;
   assign udf_err   = udf_q;

endmodule
